// File: rtl/ahb2apb_bridge_v2_if.sv
// AHB-Lite slave / APB4 master bus bundle for the AHB-to-APB bridge.
// The slave modport is the bridge view; master is the environment view
// (AHB interconnect plus APB peripherals).
interface ahb2apb_bridge_v2_if #(
    parameter int HADDR_WIDTH = 32,
    parameter int PADDR_WIDTH = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int PSLV_NUM    = 8
);
    localparam int STRB_W = DATA_WIDTH / 8;

    // AHB side
    logic                          hsel;
    logic                          hready_i;
    logic                          hwrite;
    logic [HADDR_WIDTH-1:0]        haddr;
    logic [1:0]                    htrans;
    logic [2:0]                    hsize;
    logic [3:0]                    hprot;
    logic [DATA_WIDTH-1:0]         hwdata;
    logic                          hready_o;
    logic                          hresp_o;
    logic [DATA_WIDTH-1:0]         hrdata_o;

    // APB side
    logic [PADDR_WIDTH-1:0]        paddr;
    logic [PSLV_NUM-1:0]           psel;
    logic                          penable;
    logic                          pwrite;
    logic [DATA_WIDTH-1:0]         pwdata;
    logic [STRB_W-1:0]             pstrb;
    logic [2:0]                    pprot;
    logic [PSLV_NUM-1:0]           pready_i;
    logic [PSLV_NUM-1:0]           pslverr_i;
    logic [PSLV_NUM*DATA_WIDTH-1:0] prdata_i;

    modport slave (
        input  hsel, hready_i, hwrite, haddr, htrans, hsize, hprot, hwdata,
        output hready_o, hresp_o, hrdata_o,
        output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        input  pready_i, pslverr_i, prdata_i
    );

    modport master (
        output hsel, hready_i, hwrite, haddr, htrans, hsize, hprot, hwdata,
        input  hready_o, hresp_o, hrdata_o,
        input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        output pready_i, pslverr_i, prdata_i
    );
endinterface

// File: rtl/ahb2apb_bridge_v2.sv
// AHB-Lite slave to APB4 master bridge. One transfer in flight; the
// completion cycle (IDLE, hready_o=1) can accept the next address phase.
// Decode errors, slave errors and pready timeouts return a two-cycle
// AHB ERROR response (ERR1 with hready_o low, ERR2 with hready_o high).
module ahb2apb_bridge_v2 #(
    parameter int HADDR_WIDTH    = 32,
    parameter int PADDR_WIDTH    = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int PSLV_NUM       = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    ahb2apb_bridge_v2_if.slave    bus
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SZ_MAX = $clog2(STRB_W);
    localparam int IW     = (PSLV_NUM > 1) ? $clog2(PSLV_NUM) : 1;
    localparam int LW     = (STRB_W > 1) ? $clog2(STRB_W) : 1;
    localparam int TW     = $clog2(TIMEOUT_CYCLES + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
    } state_t;

    state_t                st, nxt;
    logic [IW-1:0]         idx_q;
    logic [TW-1:0]         tmo_cnt;
    logic                  accept, dec_err, timeout_hit;
    logic [3:0]            slot;
    logic [STRB_W-1:0]     strb_d;
    logic [PSLV_NUM-1:0]   sel_oh;
    logic                  rdy_sel, err_sel;
    logic [DATA_WIDTH-1:0] rd_sel;
    logic                  unused_ok;

    assign accept    = bus.hsel & bus.hready_i & bus.htrans[1];
    assign slot      = bus.haddr[PADDR_WIDTH +: 4];
    // Out-of-range slot, any address bit above the slot field, or a transfer
    // wider than the data bus.
    assign dec_err   = (int'(slot) >= PSLV_NUM)
                     || ((bus.haddr >> (PADDR_WIDTH + 4)) != '0)
                     || (int'(bus.hsize) > SZ_MAX);
    // Abandon on the ACCESS cycle whose count reaches TIMEOUT_CYCLES, so the
    // access spans exactly TIMEOUT_CYCLES cycles without pready.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign unused_ok = ^{bus.htrans[0], bus.hprot[3:2]};

    // Byte-lane strobes: lanes sharing the size-aligned container of haddr.
    always_comb begin
        int lane;
        int sz;
        strb_d = '0;
        lane   = int'(bus.haddr[LW-1:0]) & (STRB_W - 1);
        sz     = int'(bus.hsize);
        for (int i = 0; i < STRB_W; i++)
            strb_d[i] = ((i >> sz) == (lane >> sz));
    end

    // Select the addressed slot's one-hot psel, pready, pslverr and prdata.
    always_comb begin
        sel_oh  = '0;
        rdy_sel = 1'b0;
        err_sel = 1'b0;
        rd_sel  = '0;
        for (int k = 0; k < PSLV_NUM; k++) begin
            if (idx_q == IW'(k)) begin
                sel_oh[k] = 1'b1;
                rdy_sel   = bus.pready_i[k];
                err_sel   = bus.pslverr_i[k];
                rd_sel    = bus.prdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // State register; async reset drops psel/penable immediately.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) st <= S_IDLE;
        else          st <= nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        nxt         = st;
        bus.hready_o = 1'b1;
        bus.hresp_o  = 1'b0;
        bus.psel     = '0;
        bus.penable  = 1'b0;
        case (st)
            S_IDLE: begin
                if (accept) begin
                    if (dec_err)         nxt = S_ERR1;
                    else if (bus.hwrite) nxt = S_WDATA;
                    else                 nxt = S_SETUP;
                end
            end
            S_WDATA: begin
                bus.hready_o = 1'b0;
                nxt          = S_SETUP;
            end
            S_SETUP: begin
                bus.hready_o = 1'b0;
                bus.psel     = sel_oh;
                nxt          = S_ACCESS;
            end
            S_ACCESS: begin
                bus.hready_o = 1'b0;
                bus.psel     = sel_oh;
                bus.penable  = 1'b1;
                if (rdy_sel)          nxt = err_sel ? S_ERR1 : S_IDLE;
                else if (timeout_hit) nxt = S_ERR1;
            end
            S_ERR1: begin
                bus.hready_o = 1'b0;
                bus.hresp_o  = 1'b1;
                nxt          = S_ERR2;
            end
            S_ERR2: begin
                bus.hresp_o  = 1'b1;
                nxt          = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // APB request capture, write data latch, timeout count and read return.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            idx_q        <= '0;
            tmo_cnt      <= '0;
            bus.paddr    <= '0;
            bus.pwrite   <= 1'b0;
            bus.pwdata   <= '0;
            bus.pstrb    <= '0;
            bus.pprot    <= '0;
            bus.hrdata_o <= '0;
        end else begin
            if (st == S_IDLE && accept && !dec_err) begin
                idx_q      <= slot[IW-1:0];
                bus.paddr  <= bus.haddr[PADDR_WIDTH-1:0];
                bus.pwrite <= bus.hwrite;
                bus.pstrb  <= bus.hwrite ? strb_d : '0;
                bus.pprot  <= {~bus.hprot[0], 1'b0, bus.hprot[1]};
            end
            if (st == S_WDATA)
                bus.pwdata <= bus.hwdata;
            if (st == S_SETUP)
                tmo_cnt <= '0;
            else if (st == S_ACCESS && !rdy_sel)
                tmo_cnt <= tmo_cnt + TW'(1);
            if (st == S_ACCESS && rdy_sel && !err_sel && !bus.pwrite)
                bus.hrdata_o <= rd_sel;
        end
    end
endmodule

// File: tb/tb_ahb2apb_bridge_v2.sv
// Directed bench for ahb2apb_bridge_v2. Stimulus pushes expected AHB
// responses and APB setup phases into queues; two monitors pop and
// compare whenever the bridge completes a transfer or starts an APB access.
module tb_ahb2apb_bridge_v2;
    localparam int PN = 8;
    localparam int DW = 32;

    logic hclk = 1'b0;
    logic hresetn = 1'b0;
    always #5 hclk = ~hclk;

    ahb2apb_bridge_v2_if #(.HADDR_WIDTH(32), .PADDR_WIDTH(16), .DATA_WIDTH(DW), .PSLV_NUM(PN)) bus();

    ahb2apb_bridge_v2 #(
        .HADDR_WIDTH(32), .PADDR_WIDTH(16), .DATA_WIDTH(DW),
        .PSLV_NUM(PN), .TIMEOUT_CYCLES(4)
    ) dut (
        .hclk(hclk), .hresetn(hresetn), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Slave model: pready after slv_wait ACCESS cycles unless hung.
    int slv_wait = 0;
    bit slv_err = 1'b0;
    bit slv_hang = 1'b0;
    bit hr_block = 1'b0;
    int acc_cnt = 0;
    logic [PN-1:0][DW-1:0] prd;

    assign bus.prdata_i = prd;
    assign bus.hready_i = bus.hready_o & ~hr_block;

    always_comb begin
        bus.pready_i = '0;
        if (bus.penable && !slv_hang && acc_cnt >= slv_wait)
            bus.pready_i = bus.psel;
        bus.pslverr_i = slv_err ? bus.pready_i : '0;
    end

    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn)         acc_cnt <= 0;
        else if (bus.penable) acc_cnt <= acc_cnt + 1;
        else                  acc_cnt <= 0;
    end

    typedef struct {
        string       name;
        bit          err;
        logic [31:0] rdata;
        int          waits;
    } rsp_t;

    typedef struct {
        string       name;
        logic [7:0]  psel;
        logic [15:0] paddr;
        bit          wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
    } apb_t;

    rsp_t rq[$];
    apb_t aq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic exp_rsp(input string nm, input bit err, input logic [31:0] rd, input int w);
        rsp_t r;
        r.name = nm; r.err = err; r.rdata = rd; r.waits = w;
        rq.push_back(r);
    endtask

    task automatic exp_apb(input string nm, input logic [7:0] ps, input logic [15:0] pa,
                           input bit wr, input logic [31:0] wd, input logic [3:0] st,
                           input logic [2:0] pr);
        apb_t a;
        a.name = nm; a.psel = ps; a.paddr = pa; a.wr = wr;
        a.wdata = wd; a.strb = st; a.prot = pr;
        aq.push_back(a);
    endtask

    // Response monitor: counts hready_o-low cycles and checks on the first
    // high cycle after them.
    initial begin
        int   lowcnt;
        bit   saw_err1;
        rsp_t e;
        lowcnt = 0;
        saw_err1 = 1'b0;
        forever begin
            @(negedge hclk);
            if (!hresetn) begin
                lowcnt = 0;
                saw_err1 = 1'b0;
            end else if (!bus.hready_o) begin
                lowcnt++;
                if (bus.hresp_o) saw_err1 = 1'b1;
            end else if (lowcnt > 0) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected completion: waits %0d, none expected", lowcnt);
                end else begin
                    e = rq.pop_front();
                    chk({e.name, " resp"}, {bus.hresp_o, saw_err1}, {e.err, e.err});
                    chk({e.name, " hrdata"}, bus.hrdata_o, e.rdata);
                    chk({e.name, " waits"}, lowcnt, e.waits);
                end
                lowcnt = 0;
                saw_err1 = 1'b0;
            end
        end
    end

    // APB monitor: checks every SETUP phase and holds its values through ACCESS.
    initial begin
        apb_t        a;
        logic [63:0] snap;
        snap = '0;
        forever begin
            @(negedge hclk);
            if (hresetn) begin
                if (bus.penable && bus.psel == '0) begin
                    checks++;
                    errors++;
                    $display("FAIL penable without psel");
                end
                if (bus.psel != '0 && !bus.penable) begin
                    if (aq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected psel: got %0h expected none", bus.psel);
                    end else begin
                        a = aq.pop_front();
                        chk({a.name, " psel"}, bus.psel, a.psel);
                        chk({a.name, " paddr"}, bus.paddr, a.paddr);
                        chk({a.name, " pwrite"}, bus.pwrite, a.wr);
                        chk({a.name, " pstrb"}, bus.pstrb, a.strb);
                        chk({a.name, " pprot"}, bus.pprot, a.prot);
                        if (a.wr) chk({a.name, " pwdata"}, bus.pwdata, a.wdata);
                    end
                    snap = {bus.psel, bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb, bus.pprot};
                end else if (bus.psel != '0 && bus.penable) begin
                    chk("apb hold", {bus.psel, bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb, bus.pprot}, snap);
                end
            end
        end
    end

    // Waits for the AHB completion cycle, then past ERR2 if it was an error.
    task automatic wait_done();
        int n;
        n = 0;
        while (!bus.hready_o && n < 40) begin
            @(negedge hclk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL completion timeout: hready_o stuck low after %0d cycles", n);
        end else if (bus.hresp_o) begin
            @(negedge hclk);
        end
    endtask

    // One AHB transfer, address phase driven from a negedge in an accepting cycle.
    task automatic xfer(input logic [31:0] a, input bit wr, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [3:0] prot);
        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = a;
        bus.hwrite = wr; bus.hsize = sz; bus.hprot = prot;
        @(posedge hclk);
        @(negedge hclk);
        bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwdata = wd;
        wait_done();
    endtask

    initial begin
        bus.hsel = 1'b0; bus.htrans = 2'b00; bus.haddr = '0; bus.hwrite = 1'b0;
        bus.hsize = 3'd0; bus.hprot = 4'd0; bus.hwdata = '0;
        for (int k = 0; k < PN; k++) prd[k] = 32'hA000_0000 | k;
        prd[3] = 32'hDEAD_BEEF;
        prd[5] = 32'hCAFE_0005;

        repeat (2) @(negedge hclk);
        chk("rst hready_o", bus.hready_o, 1'b1);
        chk("rst hresp_o", bus.hresp_o, 1'b0);
        chk("rst psel/penable", {bus.psel, bus.penable}, 9'h0);
        chk("rst hrdata_o", bus.hrdata_o, 32'h0);
        chk("rst apb regs", {bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb, bus.pprot}, 56'h0);
        hresetn = 1'b1;
        @(negedge hclk);

        exp_apb("rd3", 8'h08, 16'h0010, 1'b0, 32'h0, 4'h0, 3'b001);
        exp_rsp("rd3", 1'b0, 32'hDEAD_BEEF, 2);
        xfer(32'h0003_0010, 1'b0, 3'd2, 32'h0, 4'b0011);

        exp_apb("wr byte", 8'h02, 16'h0002, 1'b1, 32'h00AB_0000, 4'b0100, 3'b000);
        exp_rsp("wr byte", 1'b0, 32'hDEAD_BEEF, 3);
        xfer(32'h0001_0002, 1'b1, 3'd0, 32'h00AB_0000, 4'b0001);

        exp_apb("wr half", 8'h04, 16'h0006, 1'b1, 32'h1234_0000, 4'b1100, 3'b100);
        exp_rsp("wr half", 1'b0, 32'hDEAD_BEEF, 3);
        xfer(32'h0002_0006, 1'b1, 3'd1, 32'h1234_0000, 4'b0000);

        slv_wait = 1;
        exp_apb("rd5 wait1", 8'h20, 16'h0104, 1'b0, 32'h0, 4'h0, 3'b001);
        exp_rsp("rd5 wait1", 1'b0, 32'hCAFE_0005, 3);
        xfer(32'h0005_0104, 1'b0, 3'd2, 32'h0, 4'b0011);

        slv_wait = 2; slv_err = 1'b1;
        exp_apb("slverr", 8'h10, 16'h0000, 1'b0, 32'h0, 4'h0, 3'b001);
        exp_rsp("slverr", 1'b1, 32'hCAFE_0005, 5);
        xfer(32'h0004_0000, 1'b0, 3'd2, 32'h0, 4'b0011);
        slv_wait = 0; slv_err = 1'b0;

        exp_rsp("dec slot", 1'b1, 32'hCAFE_0005, 1);
        xfer(32'h0009_0000, 1'b0, 3'd2, 32'h0, 4'b0011);
        exp_rsp("dec high", 1'b1, 32'hCAFE_0005, 1);
        xfer(32'h0010_0000, 1'b0, 3'd2, 32'h0, 4'b0011);
        exp_rsp("dec size", 1'b1, 32'hCAFE_0005, 1);
        xfer(32'h0000_0000, 1'b0, 3'd3, 32'h0, 4'b0011);

        slv_hang = 1'b1;
        exp_apb("timeout", 8'h40, 16'h0000, 1'b0, 32'h0, 4'h0, 3'b001);
        exp_rsp("timeout", 1'b1, 32'hCAFE_0005, 6);
        xfer(32'h0006_0000, 1'b0, 3'd2, 32'h0, 4'b0011);
        slv_hang = 1'b0;

        exp_apb("after timeout", 8'h40, 16'h0008, 1'b0, 32'h0, 4'h0, 3'b001);
        exp_rsp("after timeout", 1'b0, 32'hA000_0006, 2);
        xfer(32'h0006_0008, 1'b0, 3'd2, 32'h0, 4'b0011);

        exp_apb("wr word", 8'h01, 16'h0000, 1'b1, 32'h89AB_CDEF, 4'b1111, 3'b101);
        exp_rsp("wr word", 1'b0, 32'hA000_0006, 3);
        xfer(32'h0000_0000, 1'b1, 3'd2, 32'h89AB_CDEF, 4'b0010);

        // Transfers the bridge must ignore.
        bus.hsel = 1'b1; bus.htrans = 2'b01; bus.haddr = 32'h0001_0000; bus.hwrite = 1'b0;
        @(negedge hclk);
        chk("ignore busy", {bus.hready_o, bus.hresp_o, bus.psel, bus.penable}, {1'b1, 1'b0, 8'h00, 1'b0});
        bus.hsel = 1'b0; bus.htrans = 2'b10;
        @(negedge hclk);
        chk("ignore hsel0", {bus.hready_o, bus.hresp_o, bus.psel, bus.penable}, {1'b1, 1'b0, 8'h00, 1'b0});
        bus.hsel = 1'b1; hr_block = 1'b1;
        @(negedge hclk);
        chk("ignore hready0", {bus.hready_o, bus.hresp_o, bus.psel, bus.penable}, {1'b1, 1'b0, 8'h00, 1'b0});
        bus.hsel = 1'b0; bus.htrans = 2'b00; hr_block = 1'b0;
        @(negedge hclk);
        chk("idle after ignored", {bus.hready_o, bus.hresp_o, bus.psel, bus.penable}, {1'b1, 1'b0, 8'h00, 1'b0});

        // Asynchronous reset in the middle of ACCESS.
        slv_hang = 1'b1;
        exp_apb("rst mid", 8'h80, 16'h0000, 1'b0, 32'h0, 4'h0, 3'b001);
        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h0007_0000;
        bus.hwrite = 1'b0; bus.hsize = 3'd2; bus.hprot = 4'b0011;
        @(posedge hclk);
        @(negedge hclk);
        bus.hsel = 1'b0; bus.htrans = 2'b00;
        @(negedge hclk);
        chk("rst mid in access", {bus.psel, bus.penable}, {8'h80, 1'b1});
        #2 hresetn = 1'b0;
        #1;
        chk("rst mid psel/penable", {bus.psel, bus.penable}, 9'h0);
        chk("rst mid hready/hresp", {bus.hready_o, bus.hresp_o}, 2'b10);
        @(negedge hclk);
        hresetn = 1'b1; slv_hang = 1'b0;
        chk("rst mid hrdata cleared", bus.hrdata_o, 32'h0);
        @(negedge hclk);

        exp_apb("after rst", 8'h80, 16'h0004, 1'b0, 32'h0, 4'h0, 3'b001);
        exp_rsp("after rst", 1'b0, 32'hA000_0007, 2);
        xfer(32'h0007_0004, 1'b0, 3'd2, 32'h0, 4'b0011);

        repeat (2) @(negedge hclk);
        chk("rsp queue drained", rq.size(), 0);
        chk("apb queue drained", aq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
